instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Assembles a 32-bit RV32I instruction word from decoded fields and a 32-bit immediate. It is the inverse of the core's immediate decode path. It sits between the debug/program-loader front end and instruction-memory write logic. It checks that the immediate is representable in the selected format, and buffers results in a 2-entry output queue with valid/ready handshakes on both sides.

## Interface
- ERR_COUNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
- in_format  input  3  format select: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR, 111 invalid.
- in_opcode  input  7  placed at [6:0].
- in_rd  input  5  placed at [11:7] for R/I/U/J/CSR.
- in_funct3  input  3  placed at [14:12] for R/I/S/B/CSR.
- in_rs1  input  5  placed at [19:15] for R/I/S/B/CSR (zimm for CSR-immediate forms).
- in_rs2  input  5  placed at [24:20] for R/S/B.
- in_funct7  input  7  placed at [31:25] for R only.
- in_immediate  input  32  two's-complement immediate (byte offset for B/J).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head when out_valid && out_ready.
- out_instruction  output  32  encoded word; 0 when out_error.
- out_error  output  1  immediate not representable or format 111.
- error_count  output  ERR_COUNT_WIDTH  saturating count of accepted requests with error.

## Operation
- Immediate placement:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - CSR: [31:20]=imm[11:0] (CSR address).
  - R: immediate ignored.
- Representability; any violation sets error:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - CSR: imm[31:12]=0.
  - Format 111: always error.
- Encoding is combinational on the inputs. The result {instruction, error} is written into the queue on acceptance.
- Queue: 2 entries, FIFO order, count 0..2.
  - in_ready = (count != 2) && !rst.
  - out_valid = (count != 0).
- error_count increments by 1 on each accepted erroring request and holds at all-ones.

## Timing
- Reset values (cycle after rst sampled high):
  - count=0, out_valid=0, out_instruction=0, out_error=0, error_count=0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst is released.
- Latency: a request accepted at edge N is presented with out_valid=1 from edge N to N+1. Throughput is 1 per cycle with out_ready held high.
- Push and pop in the same cycle:
  - count unchanged.
  - With count=1, the popped head is replaced by the new entry at the same edge.
- Full (count=2): in_ready=0 even if out_ready=1 that cycle. No combinational path from out_ready to in_ready.
- Empty: out_ready ignored. Output data is don't-care but holds its last value.
- out_instruction and out_error are stable while out_valid && !out_ready.
- rst mid-operation discards all queued entries at the next edge and clears error_count.

## Structure
- The shared package holds:
  - Format constants FMT_R..FMT_INV (3'b000..3'b111), the same encoding the immediate decode select uses.
  - Opcode constants.
  - A pure function encode_instr(fields, imm) returning {error, word}.
- One sub-module, encoder_queue2: a parameterised-width 2-entry FIFO with in/out valid-ready and a count register.
- Top level = encode function + encoder_queue2 + saturating error counter.

## Test plan
- addi x1,x0,-1 (fmt 001, opcode 0010011, rd 1, funct3 0, rs1 0, imm 0xFFFFFFFF), out_ready=1 -> out_instruction=0xFFF00093, out_error=0, out_valid one edge after acceptance.
- beq x1,x2,-4 (fmt 011, opcode 1100011, rs1 1, rs2 2, imm 0xFFFFFFFC) -> 0xFE208EE3. The same request with imm=0x00001000 -> out_error=1, word 0, error_count=1.
- lui x5 (fmt 100, opcode 0110111, rd 5, imm 0x12345000) -> 0x123452B7. The same request with imm=0x12345001 -> error.
- jal with imm=3 -> error. Feed 0xFFFF+2 erroring requests with ERR_COUNT_WIDTH=16 -> error_count saturates at 0xFFFF.
- Backpressure: out_ready=0, offer 3 back-to-back requests A,B,C -> A and B accepted, in_ready=0 and C held. Then out_ready=1 -> output order A,B,C; in_ready=1 in the cycle after A pops; no loss or duplication.
- Queue holding 2 entries, rst high for one cycle -> next cycle out_valid=0, error_count=0; in_ready=1 after release; a new request emerges alone.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// RV32I format/opcode constants and the pure field+immediate to instruction-word encoder.
// Latency: combinational helper only.
// Backpressure: not applicable; used inside the flow-controlled top level.
package instruction_encoder_pkg;

    localparam logic [2:0] FMT_R   = 3'b000;
    localparam logic [2:0] FMT_I   = 3'b001;
    localparam logic [2:0] FMT_S   = 3'b010;
    localparam logic [2:0] FMT_B   = 3'b011;
    localparam logic [2:0] FMT_U   = 3'b100;
    localparam logic [2:0] FMT_J   = 3'b101;
    localparam logic [2:0] FMT_CSR = 3'b110;
    localparam logic [2:0] FMT_INV = 3'b111;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [2:0] fmt;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
    } instr_fields_t;

    typedef struct packed {
        logic        error;
        logic [31:0] word;
    } enc_result_t;

    // Places the immediate per format; an immediate that does not round-trip through
    // the decoder's sign/zero extension flags an error and forces the word to zero.
    function automatic enc_result_t encode_instr(input instr_fields_t f, input logic [31:0] imm);
        enc_result_t r;
        r.error = 1'b0;
        r.word  = 32'h0;
        case (f.fmt)
            FMT_R: begin
                r.word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            end
            FMT_I: begin
                r.word  = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                r.error = (imm != {{21{imm[11]}}, imm[10:0]});
            end
            FMT_S: begin
                r.word  = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
                r.error = (imm != {{21{imm[11]}}, imm[10:0]});
            end
            FMT_B: begin
                r.word  = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
                r.error = (imm[31:12] != {20{imm[12]}}) || imm[0];
            end
            FMT_U: begin
                r.word  = {imm[31:12], f.rd, f.opcode};
                r.error = (imm[11:0] != 12'h0);
            end
            FMT_J: begin
                r.word  = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
                r.error = (imm[31:20] != {12{imm[20]}}) || imm[0];
            end
            FMT_CSR: begin
                r.word  = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                r.error = (imm[31:12] != 20'h0);
            end
            default: begin
                r.error = 1'b1;
            end
        endcase
        if (r.error) begin
            r.word = 32'h0;
        end
        return r;
    endfunction

endpackage

// File: rtl/instruction_encoder_queue2.sv
// Two-entry FIFO, head always in head_q so the output is a plain register.
// Latency: an entry written at edge N is visible at the head from edge N (when queue was empty).
// Backpressure: in_ready depends only on count and rst, never on out_ready.
module encoder_queue2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2) && !rst;
    assign out_valid = (count != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Count and storage update; head is only overwritten when new head data exists,
    // so an emptied queue keeps presenting its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head_q <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes RV32I fields + immediate into a word, queues {word, error} in a 2-deep FIFO.
// Latency: accepted request is at the output from the accepting edge; 1/cycle throughput.
// Backpressure: in_ready drops when the queue holds 2 entries or during reset.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_format,
    input  logic [6:0]                 in_opcode,
    input  logic [4:0]                 in_rd,
    input  logic [2:0]                 in_funct3,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [6:0]                 in_funct7,
    input  logic [31:0]                in_immediate,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic                       out_error,
    output logic [ERR_COUNT_WIDTH-1:0] error_count
);

    instr_fields_t fields;
    enc_result_t   enc;
    enc_result_t   head;

    assign fields = '{fmt: in_format, opcode: in_opcode, rd: in_rd, funct3: in_funct3,
                      rs1: in_rs1, rs2: in_rs2, funct7: in_funct7};
    assign enc    = encode_instr(fields, in_immediate);

    encoder_queue2 #(.WIDTH($bits(enc_result_t))) u_queue (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_instruction = head.word;
    assign out_error       = head.error;

    // Saturating count of accepted requests that carried an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_count <= '0;
        end else if (in_valid && in_ready && enc.error && (error_count != '1)) begin
            error_count <= error_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with hand-computed expected words.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Counts every comparison and prints a single summary line.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_format;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [31:0] in_immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic        out_error;
    logic [15:0] error_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ERR_COUNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_format       (in_format),
        .in_opcode       (in_opcode),
        .in_rd           (in_rd),
        .in_funct3       (in_funct3),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_funct7       (in_funct7),
        .in_immediate    (in_immediate),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_error       (out_error),
        .error_count     (error_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_format    = fmt;
        in_opcode    = op;
        in_rd        = rd;
        in_funct3    = f3;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_funct7    = f7;
        in_immediate = imm;
        in_valid     = 1'b1;
    endtask

    // Holds the currently set request until accepted, then drops in_valid.
    task automatic wait_accept(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                           input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm,
                           input logic [31:0] word, input logic err);
        set_req(fmt, op, rd, f3, rs1, rs2, f7, imm);
        wait_accept(tag);
        if (err) exp_cnt++;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_word"}, out_instruction, word);
        check({tag, "_err"}, {31'd0, out_error}, {31'd0, err});
        check({tag, "_errcnt"}, {16'd0, error_count}, exp_cnt[31:0]);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'b000, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        in_valid = 1'b0;
        tick(); tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_word", out_instruction, 32'h0);
        check("rst_err", {31'd0, out_error}, 32'd0);
        check("rst_errcnt", {16'd0, error_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Single requests with the consumer always ready.
        out_ready = 1'b1;
        run_vec("addi_m1",  3'b001, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        tick();
        check("addi_popped", {31'd0, out_valid}, 32'd0);
        run_vec("beq_m4",   3'b011, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        run_vec("beq_big",  3'b011, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h00001000, 32'h0, 1'b1);
        run_vec("beq_odd",  3'b011, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h00000006, 32'h00208363, 1'b0);
        run_vec("lui",      3'b100, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        run_vec("lui_bad",  3'b100, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345001, 32'h0, 1'b1);
        run_vec("jal_odd",  3'b101, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000003, 32'h0, 1'b1);
        run_vec("jal_2k",   3'b101, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
        run_vec("addi_max", 3'b001, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h000007FF, 32'h7FF00093, 1'b0);
        run_vec("addi_ovf", 3'b001, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800, 32'h0, 1'b1);
        run_vec("sw_m8",    3'b010, 7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'hFFFFFFF8, 32'hFE20AC23, 1'b0);
        run_vec("add",      3'b000, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
        run_vec("csrrw",    3'b110, 7'b1110011, 5'd1, 3'd1, 5'd2, 5'd0, 7'd0, 32'h00000300, 32'h300110F3, 1'b0);
        run_vec("csr_big",  3'b110, 7'b1110011, 5'd1, 3'd1, 5'd2, 5'd0, 7'd0, 32'h00001000, 32'h0, 1'b1);
        run_vec("fmt_inv",  3'b111, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000000, 32'h0, 1'b1);
        tick();

        // Backpressure: A and B fill the queue, C must wait.
        out_ready = 1'b0;
        set_req(3'b001, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        tick();
        set_req(3'b001, 7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
        tick();
        set_req(3'b001, 7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_held_ready", {31'd0, in_ready}, 32'd0);
        check("bp_head_a", out_instruction, 32'h00100093);
        out_ready = 1'b1;
        #1;
        check("bp_no_comb_path", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_head_b", out_instruction, 32'h00200113);
        check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_head_c", out_instruction, 32'h00300193);
        check("bp_c_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_hold_last", out_instruction, 32'h00300193);

        // Reset with two entries queued and a nonzero error count.
        out_ready = 1'b0;
        set_req(3'b111, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        tick();
        set_req(3'b001, 7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
        tick();
        in_valid = 1'b0;
        check("pre_rst_errcnt", {16'd0, error_count}, exp_cnt[31:0] + 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_errcnt", {16'd0, error_count}, 32'd0);
        check("rst_mid_in_ready_rel", {31'd0, in_ready}, 32'd1);
        exp_cnt = 0;
        out_ready = 1'b1;
        run_vec("post_rst", 3'b001, 7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4, 32'h00400213, 1'b0);
        tick();
        check("post_rst_alone", {31'd0, out_valid}, 32'd0);

        // Saturation: 0xFFFF+2 erroring requests back to back.
        set_req(3'b111, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        for (int i = 0; i < 32'hFFFE; i++) tick();
        check("sat_fffe", {16'd0, error_count}, 32'h0000FFFE);
        tick();
        check("sat_ffff", {16'd0, error_count}, 32'h0000FFFF);
        tick(); tick();
        in_valid = 1'b0;
        check("sat_hold", {16'd0, error_count}, 32'h0000FFFF);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
